// File: rtl/queen_pkg.sv
// Shared definitions for the board-row stack: default sizing, FSM state
// encoding and the internal operation kinds latched when a request is accepted.
package queen_pkg;

  localparam int DFLT_STACK_DEPTH = 8;  // one entry per board row
  localparam int DFLT_ENTRY_W     = 6;  // {row[5:3], column[2:0]}
  localparam int ADDR_W           = 3;  // entry index width
  localparam int DEPTH_W          = 4;  // occupancy 0..8

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_PUSH    = 2'd0,
    K_POP     = 2'd1,
    K_REPLACE = 2'd2,
    K_READ    = 2'd3
  } op_kind_t;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one combinational read port.
// Contents are not reset; occupancy tracking lives in the arbiter.
module stack_regfile
  import queen_pkg::*;
#(
  parameter int DEPTH  = DFLT_STACK_DEPTH,
  parameter int WIDTH  = DFLT_ENTRY_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates a solver (push / pop / replace) and a readout port onto one
// stack register file. Every accepted request runs IDLE -> OP -> RESP:
// storage is accessed in OP and the result pulses are visible in RESP.
module stack_arbiter
  import queen_pkg::*;
#(
  parameter int STACK_DEPTH = DFLT_STACK_DEPTH,
  parameter int ENTRY_W     = DFLT_ENTRY_W
) (
  input  logic               clk,
  input  logic               user_reset_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               stack_ready,
  output logic               underflow,
  output logic               overflow,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_index,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [DEPTH_W-1:0] depth
);

  state_t             state;
  op_kind_t           op_kind;
  logic [ENTRY_W-1:0] wdata_q;
  logic [ADDR_W-1:0]  ridx_q;

  logic               empty;
  logic               full;
  logic [ADDR_W-1:0]  top_idx;
  logic               rf_we;
  logic [ADDR_W-1:0]  rf_waddr;
  logic [ADDR_W-1:0]  rf_raddr;
  logic [ENTRY_W-1:0] rf_rdata;

  assign empty   = (depth == '0);
  assign full    = (depth == DEPTH_W'(STACK_DEPTH));
  assign top_idx = depth[ADDR_W-1:0] - ADDR_W'(1);

  // Storage port steering: only the OP cycle touches the register file,
  // and a clear arriving in that cycle suppresses the write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = depth[ADDR_W-1:0];
    rf_raddr = top_idx;
    if (state == OP && !clear) begin
      case (op_kind)
        K_PUSH:    rf_we = !full;
        K_REPLACE: begin
          rf_we    = !empty;
          rf_waddr = top_idx;
        end
        K_READ:    rf_raddr = ridx_q;
        default:   rf_we = 1'b0;
      endcase
    end
  end

  stack_regfile #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (wdata_q),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // Request sampling, operation execution and registered result pulses
  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state       <= IDLE;
      op_kind     <= K_PUSH;
      wdata_q     <= '0;
      ridx_q      <= '0;
      depth       <= '0;
      pop_data    <= '0;
      rd_data     <= '0;
      stack_ready <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
    end else if (clear) begin
      // Clear wins everywhere: empty the stack and drop any op in flight
      state       <= IDLE;
      depth       <= '0;
      stack_ready <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      stack_ready <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      case (state)
        IDLE: begin
          // Solver beats reader, so a push that shows up during a read's
          // RESP cycle is taken here ahead of a still-pending rd_req.
          if (push || pop) begin
            op_kind <= (push && pop) ? K_REPLACE : (push ? K_PUSH : K_POP);
            wdata_q <= push_data;
            state   <= OP;
          end else if (rd_req) begin
            op_kind <= K_READ;
            ridx_q  <= rd_index;
            state   <= OP;
          end
        end
        OP: begin
          state <= RESP;
          case (op_kind)
            K_PUSH: begin
              stack_ready <= 1'b1;
              if (full) overflow <= 1'b1;
              else      depth    <= depth + DEPTH_W'(1);
            end
            K_POP: begin
              stack_ready <= 1'b1;
              if (empty) begin
                underflow <= 1'b1;
              end else begin
                pop_data <= rf_rdata;
                depth    <= depth - DEPTH_W'(1);
              end
            end
            K_REPLACE: begin
              stack_ready <= 1'b1;
              if (empty) underflow <= 1'b1;
              else       pop_data  <= rf_rdata;
            end
            K_READ: begin
              rd_valid <= 1'b1;
              rd_data  <= (DEPTH_W'(ridx_q) < depth) ? rf_rdata : '0;
            end
            default: state <= IDLE;
          endcase
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed plus randomized bench for stack_arbiter; expectations come from a
// queue-based stack model and the request-to-response cycle timing.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       user_reset_n;
  logic       clear;
  logic       push;
  logic       pop;
  logic [5:0] push_data;
  logic [5:0] pop_data;
  logic       stack_ready;
  logic       underflow;
  logic       overflow;
  logic       rd_req;
  logic [2:0] rd_index;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic [3:0] depth;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] model [$];
  logic [5:0] exp_pop = '0;
  logic [5:0] exp_rd  = '0;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk          (clk),
    .user_reset_n (user_reset_n),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .push_data    (push_data),
    .pop_data     (pop_data),
    .stack_ready  (stack_ready),
    .underflow    (underflow),
    .overflow     (overflow),
    .rd_req       (rd_req),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .depth        (depth)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One solver transaction: request held until the stack_ready cycle.
  task automatic solver(input bit p, input bit q, input logic [5:0] d);
    bit e_ovf = 1'b0;
    bit e_unf = 1'b0;
    @(negedge clk);
    push = p; pop = q; push_data = d;
    if (p && !q) begin
      if (model.size() == 8) e_ovf = 1'b1;
      else model.push_back(d);
    end else if (q && !p) begin
      if (model.size() == 0) e_unf = 1'b1;
      else exp_pop = model.pop_back();
    end else begin
      if (model.size() == 0) e_unf = 1'b1;
      else begin
        exp_pop = model[model.size()-1];
        model[model.size()-1] = d;
      end
    end
    @(negedge clk);
    chk("ready_early", stack_ready, 0);
    @(negedge clk);
    chk("stack_ready", stack_ready, 1);
    chk("overflow", overflow, e_ovf);
    chk("underflow", underflow, e_unf);
    chk("pop_data", pop_data, exp_pop);
    chk("depth", depth, model.size());
    chk("rd_valid_on_solver", rd_valid, 0);
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    chk("ready_single", stack_ready, 0);
    chk("depth_after", depth, model.size());
  endtask

  // One readout transaction.
  task automatic reader(input logic [2:0] idx);
    @(negedge clk);
    rd_req = 1'b1; rd_index = idx;
    exp_rd = (idx < model.size()) ? model[idx] : 6'd0;
    @(negedge clk);
    chk("rd_valid_early", rd_valid, 0);
    @(negedge clk);
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, exp_rd);
    chk("ready_on_read", stack_ready, 0);
    chk("depth_on_read", depth, model.size());
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_single", rd_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    push_data = '0; rd_req = 1'b0; rd_index = '0;
    repeat (2) @(negedge clk);
    chk("rst_depth", depth, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", stack_ready, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    user_reset_n = 1'b1;

    // Three pushes, then pop, replace and readback of the replaced slot
    solver(1, 0, 6'h01);
    solver(1, 0, 6'h0B);
    solver(1, 0, 6'h13);
    chk("depth3", depth, 3);
    solver(0, 1, 6'h00);
    chk("pop_13", pop_data, 6'h13);
    solver(1, 1, 6'h0C);
    chk("replace_0B", pop_data, 6'h0B);
    chk("depth2", depth, 2);
    reader(3'd1);
    chk("mem1_0C", rd_data, 6'h0C);

    // Reader and push together: push first, rd_valid three cycles later
    @(negedge clk);
    push = 1'b1; push_data = 6'h21; rd_req = 1'b1; rd_index = 3'd1;
    model.push_back(6'h21);
    @(negedge clk);
    chk("mix_ready_early", stack_ready, 0);
    @(negedge clk);
    chk("mix_ready", stack_ready, 1);
    chk("mix_rd_valid_n2", rd_valid, 0);
    chk("mix_depth", depth, 3);
    push = 1'b0;
    @(negedge clk);
    chk("mix_rd_valid_n3", rd_valid, 0);
    chk("mix_ready_off", stack_ready, 0);
    @(negedge clk);
    chk("mix_rd_valid_n4", rd_valid, 0);
    @(negedge clk);
    chk("mix_rd_valid_n5", rd_valid, 1);
    chk("mix_rd_data", rd_data, model[1]);
    rd_req = 1'b0;
    solver(0, 1, 6'h00);
    reader(3'd7);
    chk("rd_beyond_depth", rd_data, 0);

    // Fill to full, overflow, then drain past empty
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; model.delete();
    for (int i = 0; i < 8; i++) solver(1, 0, 6'($urandom));
    solver(1, 0, 6'h3F);
    chk("full_depth", depth, 8);
    for (int i = 0; i < 9; i++) solver(0, 1, 6'h00);
    chk("empty_depth", depth, 0);
    solver(1, 1, 6'h2A);

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 4);
      case (r)
        0, 1: solver(1, 0, 6'($urandom));
        2:    solver(0, 1, 6'($urandom));
        3:    solver(1, 1, 6'($urandom));
        default: reader(3'($urandom));
      endcase
    end

    // Reset during the OP cycle of a push
    for (int i = 0; i < 2; i++) solver(1, 0, 6'($urandom));
    @(negedge clk);
    push = 1'b1; push_data = 6'h15;
    @(negedge clk);
    user_reset_n = 1'b0;
    #1;
    chk("rst_mid_depth", depth, 0);
    chk("rst_mid_ready", stack_ready, 0);
    push = 1'b0;
    model.delete(); exp_pop = '0; exp_rd = '0;
    @(negedge clk);
    chk("rst_mid_ready2", stack_ready, 0);
    user_reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready3", stack_ready, 0);
    chk("rst_mid_depth2", depth, 0);

    // Clear at depth 5
    for (int i = 0; i < 5; i++) solver(1, 0, 6'($urandom));
    chk("depth5", depth, 5);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; model.delete();
    chk("clear_depth", depth, 0);
    chk("clear_ready", stack_ready, 0);
    chk("clear_rd_valid", rd_valid, 0);
    chk("clear_overflow", overflow, 0);
    @(negedge clk);
    chk("clear_quiet", stack_ready, 0);
    solver(0, 1, 6'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, meaning the number of stack entries (one per board row).
REQ-002 SHALL have parameter ENTRY_W, default 6, meaning the entry width: {row[5:3], column[2:0]}.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port user_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port clear, input, 1 bit: synchronous empty-stack command.
REQ-006 SHALL have port push, input, 1 bit: solver push request, level, held until stack_ready.
REQ-007 SHALL have port pop, input, 1 bit: solver pop request, level, held until stack_ready.
REQ-008 SHALL have port push_data, input, ENTRY_W bits: entry to write.
REQ-009 SHALL have port pop_data, output, ENTRY_W bits: registered entry removed or replaced.
REQ-010 SHALL have port stack_ready, output, 1 bit: one-cycle completion pulse for a solver op.
REQ-011 SHALL have port underflow, output, 1 bit: one-cycle pulse when a pop or replace finds the stack empty.
REQ-012 SHALL have port overflow, output, 1 bit: one-cycle pulse when a push finds the stack full.
REQ-013 SHALL have port rd_req and rd_index[2:0], inputs: readout requester and the entry index it asks for (0 = bottom).
REQ-014 SHALL have port rd_data, output, ENTRY_W bits, plus rd_valid, output, 1 bit: readout result and its one-cycle valid pulse.
REQ-015 SHALL have port depth, output, 4 bits: current occupancy, 0..8.

Function
REQ-016 SHALL use the FSM IDLE -> OP -> RESP -> IDLE. OP and RESP each last exactly one cycle.
REQ-017 SHALL sample requests only in IDLE, with priority clear > solver (push/pop) > reader. Requests in OP/RESP are ignored, not queued.
REQ-018 SHALL handle clear in any state: depth := 0, FSM := IDLE next cycle, no pulses issued, any op in flight aborted.
REQ-019 SHALL, for push only: if depth==8, pulse overflow and stack_ready in RESP with depth unchanged; else write mem[depth] in OP and increment depth.
REQ-020 SHALL, for pop only: if depth==0, pulse underflow and stack_ready in RESP; else load pop_data from mem[depth-1] in OP and decrement depth.
REQ-021 SHALL, for push and pop together (replace): if depth==0, treat as underflow per REQ-020; else load pop_data from old mem[depth-1] and write push_data there, with depth unchanged.
REQ-022 SHALL give solver-op latency: request seen in IDLE at cycle N, stack_ready high in cycle N+2 only; the requester deasserts at N+3.
REQ-023 SHALL, for a reader op, pulse rd_valid in RESP (cycle N+2). rd_data SHALL be mem[rd_index] if rd_index < depth, else 0. Stack contents and depth SHALL be unchanged.
REQ-024 SHALL assert stack_ready, overflow and underflow only in RESP, and only for solver ops; rd_valid SHALL be asserted only for reader ops.
REQ-025 SHALL hold pop_data and rd_data between ops; depth SHALL never wrap below 0 or above 8.
REQ-026 SHALL, when push arrives in the RESP cycle of a reader op, serve it in the following IDLE cycle; the reader SHALL NOT starve the solver.

Reset
REQ-027 SHALL, while user_reset_n is low, immediately force: FSM=IDLE, depth=0, pop_data=0, rd_data=0, stack_ready=0, underflow=0, overflow=0, rd_valid=0.
REQ-028 SHALL abort any op in flight on reset mid-operation, with no completion pulse afterwards. Memory contents need not be reset.

Structure
REQ-029 SHALL take STACK_DEPTH, ENTRY_W and the FSM state encoding (IDLE, OP, RESP) from shared package queen_pkg.
REQ-030 SHALL instantiate one sub-module, stack_regfile: 8 x ENTRY_W, one synchronous write port, one combinational read port, no reset.

Verification
REQ-031 SHALL cover: push 0x01, 0x0B, 0x13 -> three stack_ready pulses, each 2 cycles after request; depth=3.
REQ-032 SHALL cover: from depth=3, pop -> pop_data=0x13 with stack_ready; then replace with push_data=0x0C -> pop_data=0x0B, depth=2, mem[1]=0x0C.
REQ-033 SHALL cover: 8 pushes then a 9th -> overflow and stack_ready together, depth=8; then pop repeatedly until underflow pulses at depth=0.
REQ-034 SHALL cover: rd_req index 1 together with push -> push served first; rd_valid 3 cycles later than the push's stack_ready, rd_data=mem[1]; rd_index 7 at depth=2 -> rd_data=0.
REQ-035 SHALL cover: user_reset_n low during OP of a push -> no stack_ready, depth=0; clear at depth=5 -> depth=0 next cycle, no pulses.
